cycle_timer: RTL and testbench
==============================

CYCLE_TIMER -- requirements
Module: cycle_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the bit width of the period, countdown and tick-count paths.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port cycles_num, input, WIDTH, the period value delivered by the upstream SPI receive stage.
REQ-005 The block SHALL have port cycles_num_rdy, input, 1, a one-clk pulse marking cycles_num valid.
REQ-006 The block SHALL have port start, input, 1, a run request, sampled each clk.
REQ-007 The block SHALL have port abort, input, 1, which stops a run immediately.
REQ-008 The block SHALL have port continuous, input, 1; 1 selects free-running reload and 0 selects one-shot.
REQ-009 The block SHALL have port busy, output, 1, high while in RUN.
REQ-010 The block SHALL have port tick, output, 1, a one-clk pulse at each period expiry.
REQ-011 The block SHALL have port done, output, 1, a one-clk pulse at the end of a one-shot run.
REQ-012 The block SHALL have port tick_cnt, output, WIDTH, the number of ticks since the last accepted start.
REQ-013 The block SHALL have port cfg_err, output, 1, a sticky flag set when a zero period is offered.

Function
REQ-014 The block SHALL keep period register per_q (reset 0), loaded from cycles_num on any clk where cycles_num_rdy=1 and cycles_num!=0, in every state.
REQ-015 The block SHALL leave per_q unchanged and set cfg_err on a clk where cycles_num_rdy=1 and cycles_num=0.
REQ-016 The block SHALL clear cfg_err only on the next accepted start or on reset.
REQ-017 The block SHALL implement exactly three states: IDLE, RUN and DONE.
REQ-018 IDLE -> RUN: when start=1, abort=0 and per_q!=0, load the countdown with per_q-1, clear tick_cnt and set busy=1 from the next clk.
REQ-019 The block SHALL ignore start while per_q=0 (stay IDLE, set cfg_err) and SHALL ignore start in RUN or DONE.
REQ-020 RUN: the countdown SHALL decrement by 1 per clk; at countdown=0 the block SHALL pulse tick for one clk and increment tick_cnt, saturating at 2^WIDTH-1.
REQ-021 The first tick SHALL be high exactly N clk cycles after the edge that accepted start, where N=per_q at acceptance; N=1 gives tick on the immediately following cycle.
REQ-022 At expiry with continuous=1, the block SHALL reload the countdown with the current per_q-1 (a new rdy value takes effect from the next period) and stay in RUN.
REQ-023 At expiry with continuous=0, the block SHALL go to DONE; done SHALL be high for that one DONE cycle, coincident with the final tick's successor cycle; then the block SHALL return to IDLE.
REQ-024 abort=1 in RUN SHALL force IDLE on that edge, with no tick or done generated for that edge, busy low on the next cycle, and tick_cnt held.
REQ-025 When start and abort are high together, abort SHALL win.
REQ-026 An abort coinciding with countdown=0 SHALL suppress the tick.
REQ-027 continuous SHALL be sampled only at expiry; changing it mid-period SHALL have no other effect.
REQ-028 A cycles_num_rdy pulse in the same clk as start acceptance SHALL update per_q, while that run uses the old per_q for its first period.

Reset
REQ-029 On rst_n=0 the block SHALL go to IDLE asynchronously with per_q=0, countdown=0, tick_cnt=0, busy=0, tick=0, done=0 and cfg_err=0.
REQ-030 Reset asserted mid-RUN SHALL end the run with no done and no tick.
REQ-031 Operation SHALL resume on the first clk edge after rst_n rises.

Verification
REQ-032 One-shot: load cycles_num=5 via rdy, start pulse with continuous=0 -> tick on cycle 5 after start, done one cycle later, tick_cnt=1, busy low after done.
REQ-033 Continuous: per_q=3, start, continuous=1 for 10 clk -> ticks at cycles 3, 6, 9; tick_cnt=3; busy stays high.
REQ-034 Reload update: per_q=4 running continuous, rdy with 2 at cycle 2 -> ticks at 4, 6, 8.
REQ-035 Abort: per_q=4, start, abort at cycle 4 (countdown=0) -> no tick, IDLE, busy=0 next cycle, tick_cnt=0.
REQ-036 Zero period: rdy with cycles_num=0 then start -> cfg_err=1, stays IDLE, per_q unchanged; a valid rdy then start clears cfg_err.
REQ-037 Reset mid-run: rst_n low during RUN -> all outputs 0 immediately, no done pulse after release.

Source files
------------

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - programmable period timer with one-shot/continuous modes
// Ticks every per_q cycles while running; cfg_err flags zero-period offers.
module cycle_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cycles_num,
  input  logic             cycles_num_rdy,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [WIDTH-1:0] tick_cnt,
  output logic             cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_per;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_ticks;
  logic             r_err;

  logic w_rdy_ok;
  logic w_rdy_zero;
  logic w_start_ok;
  logic w_start_bad;
  logic w_expire;

  assign w_rdy_ok    = cycles_num_rdy && (cycles_num != '0);
  assign w_rdy_zero  = cycles_num_rdy && (cycles_num == '0);
  assign w_start_ok  = (r_state == S_IDLE) && start && !abort && (r_per != '0);
  assign w_start_bad = (r_state == S_IDLE) && start && !abort && (r_per == '0);
  // Abort on the expiry cycle swallows the tick, so expiry is gated by it.
  assign w_expire    = (r_state == S_RUN) && (r_cnt == '0) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    tick        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        tick = w_expire;
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_expire && !continuous) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per   <= '0;
      r_cnt   <= '0;
      r_ticks <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_rdy_ok) r_per <= cycles_num;

      if (w_rdy_zero || w_start_bad) begin
        r_err <= 1'b1;
      end else if (w_start_ok) begin
        r_err <= 1'b0;
      end

      // Reload reads r_per before any same-edge rdy update lands.
      if (w_start_ok) begin
        r_cnt <= r_per - ONE;
      end else if ((r_state == S_RUN) && !abort) begin
        if (r_cnt == '0) begin
          r_cnt <= r_per - ONE;
        end else begin
          r_cnt <= r_cnt - ONE;
        end
      end

      if (w_start_ok) begin
        r_ticks <= '0;
      end else if (w_expire && (r_ticks != '1)) begin
        r_ticks <= r_ticks + ONE;
      end
    end
  end

  assign tick_cnt = r_ticks;
  assign cfg_err  = r_err;

endmodule

// File: tb/tb_cycle_timer.sv
// tb/tb_cycle_timer.sv - scoreboard bench for cycle_timer
// Model tracks elapsed cycles within each period and expects a tick when it reaches the period length.
module tb_cycle_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] cycles_num = '0;
  logic         cycles_num_rdy = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         continuous = 1'b0;
  logic         busy;
  logic         tick;
  logic         done;
  logic [W-1:0] tick_cnt;
  logic         cfg_err;

  cycle_timer #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cycles_num     (cycles_num),
    .cycles_num_rdy (cycles_num_rdy),
    .start          (start),
    .abort          (abort),
    .continuous     (continuous),
    .busy           (busy),
    .tick           (tick),
    .done           (done),
    .tick_cnt       (tick_cnt),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic busy;
    logic tick;
    logic done;
    logic err;
    int   cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference state: 0 idle, 1 running, 2 done-pulse cycle
  int m_mode = 0;
  int m_per = 0;
  int m_len = 0;
  int m_elapsed = 0;
  int m_ticks = 0;
  bit m_err = 0;

  task automatic model();
    exp_t e;
    int   max_cnt;
    bit   expired;
    max_cnt = (1 << W) - 1;
    e.cyc = cyc;
    if (!rst_n) begin
      e.busy = 0; e.tick = 0; e.done = 0; e.err = 0; e.cnt = 0;
      m_mode = 0; m_per = 0; m_len = 0; m_elapsed = 0; m_ticks = 0; m_err = 0;
      q.push_back(e);
      return;
    end
    expired = (m_mode == 1) && (m_elapsed == m_len) && !abort;
    e.busy = (m_mode == 1);
    e.tick = expired;
    e.done = (m_mode == 2);
    e.err  = m_err;
    e.cnt  = m_ticks;
    q.push_back(e);

    if (cycles_num_rdy && cycles_num == 0) m_err = 1;
    case (m_mode)
      0: if (start && !abort) begin
        if (m_per == 0) begin
          m_err = 1;
        end else begin
          if (!(cycles_num_rdy && cycles_num == 0)) m_err = 0;
          m_mode = 1; m_len = m_per; m_elapsed = 1; m_ticks = 0;
        end
      end
      1: if (abort) begin
        m_mode = 0;
      end else if (expired) begin
        if (m_ticks < max_cnt) m_ticks++;
        if (continuous) begin
          m_len = m_per; m_elapsed = 1;
        end else begin
          m_mode = 2;
        end
      end else begin
        m_elapsed++;
      end
      default: m_mode = 0;
    endcase
    if (cycles_num_rdy && cycles_num != 0) m_per = int'(cycles_num);
  endtask

  task automatic drive(input logic rdy, input int num, input logic st, input logic ab,
                       input logic cont, input logic rn);
    @(negedge clk);
    cycles_num_rdy = rdy;
    cycles_num     = W'(num);
    start          = st;
    abort          = ab;
    continuous     = cont;
    rst_n          = rn;
    cyc++;
    model();
  endtask

  task automatic idle(input int n, input logic cont);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, cont, 1);
  endtask

  task automatic chk(input string name, input int c, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, c, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("busy",     e.cyc, int'(busy),     int'(e.busy));
        chk("tick",     e.cyc, int'(tick),     int'(e.tick));
        chk("done",     e.cyc, int'(done),     int'(e.done));
        chk("cfg_err",  e.cyc, int'(cfg_err),  int'(e.err));
        chk("tick_cnt", e.cyc, int'(tick_cnt), e.cnt);
      end
    end
  end

  initial begin : stim
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 5, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1);

    // one-shot, period 5
    drive(1, 5, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 1);
    idle(8, 0);
    // continuous, period 3
    drive(1, 3, 0, 0, 1, 1);
    drive(0, 0, 1, 0, 1, 1);
    idle(10, 1);
    drive(0, 0, 0, 1, 1, 1);
    // period 4 continuous with reload to 2 at cycle 2
    drive(1, 4, 0, 0, 1, 1);
    drive(0, 0, 1, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(1, 2, 0, 0, 1, 1);
    idle(7, 1);
    drive(0, 0, 0, 1, 1, 1);
    // abort on the expiry cycle
    drive(1, 4, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 1);
    idle(3, 0);
    drive(0, 0, 0, 1, 0, 1);
    idle(3, 0);
    // start and abort together, then period 1
    drive(1, 1, 1, 1, 0, 1);
    drive(0, 0, 1, 0, 0, 1);
    idle(4, 0);
    // zero period from reset, then valid period clears the error
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 1);
    idle(2, 0);
    drive(1, 2, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 1);
    idle(4, 0);
    // rdy coinciding with start: first period uses old value
    drive(1, 6, 1, 0, 1, 1);
    idle(14, 1);
    drive(0, 0, 0, 1, 1, 1);
    // saturation with period 1
    drive(1, 1, 0, 0, 1, 1);
    drive(0, 0, 1, 0, 1, 1);
    idle(20, 1);
    // reset mid-run
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    idle(4, 1);

    for (int i = 0; i < 2500; i++) begin
      logic rdy, st, ab, cont, rn;
      int   num;
      rdy  = ($urandom_range(0, 9) == 0);
      num  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      st   = ($urandom_range(0, 3) == 0);
      ab   = ($urandom_range(0, 24) == 0);
      cont = ($urandom_range(0, 2) != 0);
      rn   = ($urandom_range(0, 199) != 0);
      drive(rdy, num, st, ab, cont, rn);
    end

    idle(3, 0);
    @(negedge clk);
    #5;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
